// File: rtl/keccak_pkg.sv
// Shared Keccak constants and the squeeze FSM state type.
// Lane i of the flat 1600-bit state holds A[x = i mod 5][y = i div 5] at bits [64*i +: 64].
package keccak_pkg;

  localparam int unsigned ROW_SIZE       = 5;
  localparam int unsigned COL_SIZE       = 5;
  localparam int unsigned LANE_SIZE      = 64;
  localparam int unsigned NUM_LANES      = ROW_SIZE * COL_SIZE;
  localparam int unsigned STATE_WIDTH    = ROW_SIZE * COL_SIZE * LANE_SIZE;
  localparam int unsigned RATE_WIDTH     = 11;
  localparam int unsigned OUT_LEN_WIDTH  = 16;
  localparam int unsigned LANE_IDX_WIDTH = 5;

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StPermWait
  } squeeze_state_e;

endpackage

// File: rtl/keccak_lane_select.sv
// Combinational lane extraction from a flat 1600-bit Keccak state.
// Ports:
//   i_state    - flat state, lane i at bits [64*i +: 64]
//   i_lane_idx - lane index 0..24
//   o_lane     - selected lane (zero for out-of-range indices)
module keccak_lane_select
  import keccak_pkg::*;
(
  input  logic [STATE_WIDTH-1:0]    i_state,
  input  logic [LANE_IDX_WIDTH-1:0] i_lane_idx,
  output logic [LANE_SIZE-1:0]      o_lane
);

  always_comb begin
    o_lane = '0;
    for (int i = 0; i < int'(NUM_LANES); i++) begin
      if (i_lane_idx == LANE_IDX_WIDTH'(i)) begin
        o_lane = i_state[i*LANE_SIZE +: LANE_SIZE];
      end
    end
  end

endmodule

// File: rtl/keccak_squeeze.sv
// Keccak squeeze phase: streams the rate portion of a permuted state as an
// AXI4-Stream source, one lane per beat, requesting further permutations when
// the rate is exhausted before the requested digest length.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   start_i             - one-cycle request to squeeze state_array_i
//   state_array_i       - permuted state (captured on start / perm_done_i)
//   rate_i, out_len_i   - rate in bits (multiple of 64), digest length in bytes
//   perm_req_o          - level request for another permutation
//   perm_done_i         - pulse: state_array_i holds the new permuted state
//   t_data_o .. t_ready_i - AXI4-Stream source
//   busy_o, done_o      - not idle; one-cycle completion pulse
module keccak_squeeze
  import keccak_pkg::*;
#(
  parameter int unsigned DWIDTH     = 64,
  parameter int unsigned KEEP_WIDTH = DWIDTH / 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic [STATE_WIDTH-1:0]   state_array_i,
  input  logic [RATE_WIDTH-1:0]    rate_i,
  input  logic [OUT_LEN_WIDTH-1:0] out_len_i,
  output logic                     perm_req_o,
  input  logic                     perm_done_i,
  output logic [DWIDTH-1:0]        t_data_o,
  output logic [KEEP_WIDTH-1:0]    t_keep_o,
  output logic                     t_valid_o,
  output logic                     t_last_o,
  input  logic                     t_ready_i,
  output logic                     busy_o,
  output logic                     done_o
);

  localparam logic [OUT_LEN_WIDTH-1:0]  BeatBytes = OUT_LEN_WIDTH'(KEEP_WIDTH);
  localparam logic [KEEP_WIDTH-1:0]     KeepAll   = '1;
  localparam logic [LANE_IDX_WIDTH-1:0] LastLane  = LANE_IDX_WIDTH'(NUM_LANES - 1);

  squeeze_state_e             r_state, w_state_next;
  logic [STATE_WIDTH-1:0]     r_buf;
  logic [RATE_WIDTH-1:0]      r_rate_lanes, w_rate_lanes_next;
  logic [OUT_LEN_WIDTH-1:0]   r_remaining, w_remaining_next;
  logic [LANE_IDX_WIDTH-1:0]  r_lane_idx, w_lane_idx_next;
  logic                       r_done, w_done_next;
  logic                       w_load;

  logic [LANE_SIZE-1:0]       w_lane;
  logic [OUT_LEN_WIDTH-1:0]   w_take;
  logic [KEEP_WIDTH-1:0]      w_keep;
  logic                       w_last;
  logic                       w_rate_end;

  keccak_lane_select u_lane_select (
    .i_state    (r_buf),
    .i_lane_idx (r_lane_idx),
    .o_lane     (w_lane)
  );

  assign w_take = (r_remaining < BeatBytes) ? r_remaining : BeatBytes;
  assign w_keep = (r_remaining >= BeatBytes) ? KeepAll : (KeepAll >> (BeatBytes - r_remaining));
  assign w_last = (r_remaining <= BeatBytes);
  // Also stop at the physical last lane so an oversized rate cannot index past the state.
  assign w_rate_end = (r_lane_idx == LastLane) ||
                      (RATE_WIDTH'(r_lane_idx) + RATE_WIDTH'(1) >= r_rate_lanes);

  always_comb begin
    w_state_next      = r_state;
    w_load            = 1'b0;
    w_rate_lanes_next = r_rate_lanes;
    w_remaining_next  = r_remaining;
    w_lane_idx_next   = r_lane_idx;
    w_done_next       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start_i) begin
          if (out_len_i == '0) begin
            w_done_next = 1'b1;
          end else begin
            w_load            = 1'b1;
            w_rate_lanes_next = rate_i >> 6;
            w_remaining_next  = out_len_i;
            w_lane_idx_next   = '0;
            w_state_next      = StStream;
          end
        end
      end
      StStream: begin
        if (t_ready_i) begin
          w_remaining_next = r_remaining - w_take;
          w_lane_idx_next  = r_lane_idx + LANE_IDX_WIDTH'(1);
          // Last beat wins over the rate boundary.
          if (w_last) begin
            w_state_next = StIdle;
            w_done_next  = 1'b1;
          end else if (w_rate_end) begin
            w_state_next = StPermWait;
          end
        end
      end
      StPermWait: begin
        if (perm_done_i) begin
          w_load          = 1'b1;
          w_lane_idx_next = '0;
          w_state_next    = StStream;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= StIdle;
      r_buf        <= '0;
      r_rate_lanes <= '0;
      r_remaining  <= '0;
      r_lane_idx   <= '0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_rate_lanes <= w_rate_lanes_next;
      r_remaining  <= w_remaining_next;
      r_lane_idx   <= w_lane_idx_next;
      r_done       <= w_done_next;
      if (w_load) begin
        r_buf <= state_array_i;
      end
    end
  end

  // Outputs decode from registers only, so they are stable under backpressure
  // and drop to zero as soon as rst is asserted.
  assign t_valid_o  = (r_state == StStream);
  assign t_data_o   = t_valid_o ? DWIDTH'(w_lane) : '0;
  assign t_keep_o   = t_valid_o ? w_keep : '0;
  assign t_last_o   = t_valid_o & w_last;
  assign perm_req_o = (r_state == StPermWait);
  assign busy_o     = (r_state != StIdle);
  assign done_o     = r_done;

endmodule

// File: tb/tb_keccak_squeeze.sv
module tb_keccak_squeeze;
  import keccak_pkg::*;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     start_i;
  logic [STATE_WIDTH-1:0]   state_array_i;
  logic [RATE_WIDTH-1:0]    rate_i;
  logic [OUT_LEN_WIDTH-1:0] out_len_i;
  logic                     perm_req_o;
  logic                     perm_done_i;
  logic [63:0]              t_data_o;
  logic [7:0]               t_keep_o;
  logic                     t_valid_o;
  logic                     t_last_o;
  logic                     t_ready_i;
  logic                     busy_o;
  logic                     done_o;

  keccak_squeeze #(.DWIDTH(64), .KEEP_WIDTH(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .state_array_i (state_array_i),
    .rate_i        (rate_i),
    .out_len_i     (out_len_i),
    .perm_req_o    (perm_req_o),
    .perm_done_i   (perm_done_i),
    .t_data_o      (t_data_o),
    .t_keep_o      (t_keep_o),
    .t_valid_o     (t_valid_o),
    .t_last_o      (t_last_o),
    .t_ready_i     (t_ready_i),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // One state per permutation of a job: blk_state[k] is the state after k extra permutations.
  logic [STATE_WIDTH-1:0] blk_state [0:15];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic set_lanes_linear(input int blk, input int base);
    for (int i = 0; i < 25; i++) blk_state[blk][i*64 +: 64] = 64'(base + i);
  endtask

  task automatic set_lanes_random(input int blk);
    for (int i = 0; i < 25; i++) blk_state[blk][i*64 +: 64] = {$urandom, $urandom};
  endtask

  // Runs one squeeze job; must be entered at a negedge and returns at a negedge.
  // ready_mode: 0 always ready, 1 random, 2 ready low for 3 cycles on beat 2.
  // perm_delay: cycles between perm_req_o and perm_done_i, negative for random.
  task automatic run_job(input int rate, input int len, input int ready_mode,
                         input int perm_delay, input bit noise);
    int rl        = rate / 64;
    int nbeats    = (len + 7) / 8;
    int beat      = 0;
    int perms     = 0;
    int cyc       = 0;
    int wait_cnt  = 0;
    int bp_cnt    = 0;
    int cur_delay = (perm_delay < 0) ? int'($urandom_range(0, 4)) : perm_delay;
    bit done_seen = 0;
    bit rdy;
    int rem;
    logic [63:0] exp_data;
    logic [7:0]  exp_keep;

    rate_i        = RATE_WIDTH'(rate);
    out_len_i     = OUT_LEN_WIDTH'(len);
    state_array_i = blk_state[0];
    start_i       = 1'b1;
    perm_done_i   = 1'b0;
    @(negedge clk);
    start_i = 1'b0;
    chk("first_valid", t_valid_o, 1);
    chk("busy_on_start", busy_o, 1);

    while (cyc < 4000) begin
      start_i     = 1'b0;
      perm_done_i = 1'b0;
      if (done_o) begin
        done_seen = 1;
        chk("beats_at_done", beat, nbeats);
        chk("valid_at_done", t_valid_o, 0);
        break;
      end
      if (t_valid_o) begin
        if (beat >= nbeats) begin
          chk("extra_beat", beat, nbeats - 1);
          exp_data = '0;
          exp_keep = '0;
        end else begin
          rem      = len - 8 * beat;
          exp_data = blk_state[beat / rl][(beat % rl)*64 +: 64];
          exp_keep = (rem >= 8) ? 8'hFF : 8'((1 << rem) - 1);
          chk("data", t_data_o, exp_data);
          chk("keep", t_keep_o, exp_keep);
          chk("last", t_last_o, (rem <= 8));
          chk("no_perm_req_streaming", perm_req_o, 0);
        end
        case (ready_mode)
          0:       rdy = 1;
          1:       rdy = ($urandom % 3) != 0;
          default: begin
            rdy = !(beat == 2 && bp_cnt < 3);
            if (!rdy) bp_cnt++;
          end
        endcase
        t_ready_i = rdy;
        if (rdy) beat++;
      end else if (perm_req_o) begin
        chk("perm_at_boundary", (beat % rl == 0) && (beat < nbeats), 1);
        t_ready_i = 1'($urandom % 2);
        if (wait_cnt >= cur_delay) begin
          perm_done_i   = 1'b1;
          state_array_i = blk_state[beat / rl];
          perms++;
          wait_cnt  = 0;
          cur_delay = (perm_delay < 0) ? int'($urandom_range(0, 4)) : perm_delay;
        end else begin
          wait_cnt++;
        end
      end else begin
        chk("no_progress", t_valid_o | perm_req_o, 1);
      end
      if (noise && !perm_req_o && busy_o) begin
        if ($urandom % 6 == 0) begin
          start_i   = 1'b1;
          out_len_i = OUT_LEN_WIDTH'($urandom_range(1, 500));
        end
        if ($urandom % 5 == 0) begin
          perm_done_i = 1'b1;
          for (int i = 0; i < 25; i++) state_array_i[i*64 +: 64] = {$urandom, $urandom};
        end
      end
      @(negedge clk);
      cyc++;
    end
    chk("job_timeout", done_seen, 1);
    chk("perm_count", perms, (nbeats - 1) / rl);
    t_ready_i = 1'b0;
    @(negedge clk);
    chk("done_one_cycle", done_o, 0);
    chk("idle_after_done", busy_o, 0);
  endtask

  // Starts a 200-byte job and asserts rst either on beat 2 or in the permutation wait.
  task automatic reset_mid(input bit in_perm);
    int beat = 0;
    int cyc  = 0;
    set_lanes_linear(0, 0);
    set_lanes_linear(1, 100);
    rate_i        = RATE_WIDTH'(1088);
    out_len_i     = OUT_LEN_WIDTH'(200);
    state_array_i = blk_state[0];
    t_ready_i     = 1'b1;
    start_i       = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    while (cyc < 200) begin
      if (!in_perm && t_valid_o && beat == 2) break;
      if (in_perm && perm_req_o) break;
      if (t_valid_o) beat++;
      @(negedge clk);
      cyc++;
    end
    chk(in_perm ? "rst_reach_perm" : "rst_reach_beat2", cyc < 200, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_data", t_data_o, 0);
    chk("rst_keep", t_keep_o, 0);
    chk("rst_valid", t_valid_o, 0);
    chk("rst_last", t_last_o, 0);
    chk("rst_perm_req", perm_req_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    @(negedge clk);
    rst = 1'b0;
    // First edge after release must accept a new start.
    set_lanes_random(0);
    run_job(1088, 8, 0, 0, 0);
  endtask

  initial begin
    int rates [5] = '{576, 832, 1088, 1152, 1344};
    rst           = 1'b1;
    start_i       = 1'b0;
    state_array_i = '0;
    rate_i        = '0;
    out_len_i     = '0;
    perm_done_i   = 1'b0;
    t_ready_i     = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_valid", t_valid_o, 0);
    chk("reset_busy", busy_o, 0);
    chk("reset_done", done_o, 0);
    chk("reset_perm_req", perm_req_o, 0);
    chk("reset_data", t_data_o, 0);
    rst = 1'b0;

    // SHA3-256
    set_lanes_linear(0, 0);
    run_job(1088, 32, 0, 0, 0);
    // partial final beat
    run_job(1088, 13, 0, 0, 0);
    // SHAKE128 with one extra permutation
    set_lanes_linear(0, 0);
    set_lanes_linear(1, 100);
    run_job(1344, 200, 0, 5, 0);
    // backpressure on beat 2
    set_lanes_random(0);
    run_job(1088, 40, 2, 0, 0);

    // zero length
    out_len_i = '0;
    start_i   = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk("zero_len_done", done_o, 1);
    chk("zero_len_valid", t_valid_o, 0);
    chk("zero_len_busy", busy_o, 0);
    @(negedge clk);
    chk("zero_len_done_clear", done_o, 0);
    chk("zero_len_valid2", t_valid_o, 0);

    reset_mid(0);
    reset_mid(1);

    for (int j = 0; j < 20; j++) begin
      for (int b = 0; b < 16; b++) set_lanes_random(b);
      run_job(rates[$urandom % 5], int'($urandom_range(1, 400)), 1, -1, 1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
